// File: rtl/mem_access_pkg.sv
// Shared types and constants for the mem_access load/store unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 64;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
            default:                        f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: f3_misaligned = off[0];
            F3_W:        f3_misaligned = (off != 2'b00);
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data and load extract / extend.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, byte enables and sign/zero extension
    always_comb begin
        be      = 4'b0000;
        wdata   = 32'h0000_0000;
        ld_data = 32'h0000_0000;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B: begin
                be      = BE_BYTE << offset;
                wdata   = {4{store_data[7:0]}};
                ld_data = {{24{byte_s[7]}}, byte_s};
            end
            F3_BU: begin
                be      = BE_BYTE << offset;
                wdata   = {4{store_data[7:0]}};
                ld_data = {24'h00_0000, byte_s};
            end
            F3_H: begin
                be      = BE_HALF << {offset[1], 1'b0};
                wdata   = {2{store_data[15:0]}};
                ld_data = {{16{half_s[15]}}, half_s};
            end
            F3_HU: begin
                be      = BE_HALF << {offset[1], 1'b0};
                wdata   = {2{store_data[15:0]}};
                ld_data = {16'h0000, half_s};
            end
            F3_W: begin
                be      = BE_WORD;
                wdata   = store_data;
                ld_data = rdata;
            end
            default: begin
                be      = 4'b0000;
                wdata   = 32'h0000_0000;
                ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store unit bridging the core to a grant/response memory bus.
// Optional MEM_ACCESS_MISALIGN_CHK_EN turns misaligned H/W accesses into error completions.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata
);

    state_t      state_r, state_s;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        we_r;
    logic [7:0]  cnt_r;
    logic        done_r, err_r, mem_req_r, mem_we_r;
    logic [31:0] load_data_r, mem_addr_r, mem_wdata_r;
    logic [3:0]  mem_be_r;

    logic        req_s, bad_s, capture_s, we_s, timeout_s;
    logic        done_s, err_s;
    logic [31:0] ld_next_s;
    logic [8:0]  cnt_inc_s;
    logic [2:0]  sel_f3_s;
    logic [1:0]  sel_off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, ld_data_s;

    assign req_s = load_en | store_en;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    assign bad_s = ~f3_legal(funct3) | f3_misaligned(funct3, addr[1:0]);
`else
    assign bad_s = ~f3_legal(funct3);
`endif
    assign capture_s = (state_r == ST_IDLE) & req_s & ~bad_s;
    assign we_s      = (state_r == ST_IDLE) ? store_en : we_r;
    assign cnt_inc_s = {1'b0, cnt_r} + 9'd1;
    assign timeout_s = (cnt_inc_s >= 9'(TIMEOUT));

    // Lane logic sees live inputs while idle, the captured access afterwards
    assign sel_f3_s  = (state_r == ST_IDLE) ? funct3 : funct3_r;
    assign sel_off_s = (state_r == ST_IDLE) ? addr[1:0] : off_r;

    mem_lane_align u_align (
        .funct3     (sel_f3_s),
        .offset     (sel_off_s),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .ld_data    (ld_data_s)
    );

    // Next-state and completion decode
    always_comb begin
        state_s   = state_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        ld_next_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (req_s && bad_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else if (req_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else if (mem_gnt) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    state_s   = ST_DONE;
                    done_s    = 1'b1;
                    err_s     = mem_err;
                    ld_next_s = we_r ? 32'h0000_0000 : ld_data_s;
                end else if (timeout_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs, captured access and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            load_data_r <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            we_r        <= 1'b0;
            cnt_r       <= 8'h00;
        end else begin
            state_r     <= state_s;
            done_r      <= done_s;
            err_r       <= err_s;
            load_data_r <= ld_next_s;
            mem_req_r   <= (state_s == ST_REQ);
            mem_we_r    <= (state_s == ST_REQ) & we_s;
            if (capture_s) begin
                mem_addr_r  <= {addr[31:2], 2'b00};
                mem_be_r    <= be_s;
                mem_wdata_r <= wdata_s;
                funct3_r    <= funct3;
                off_r       <= addr[1:0];
                we_r        <= store_en;
            end
            if (state_r == ST_IDLE) begin
                cnt_r <= 8'h00;
            end else if (((state_r == ST_REQ) || (state_r == ST_RESP)) && (cnt_r != 8'hFF)) begin
                cnt_r <= cnt_inc_s[7:0];
            end
        end
    end

    assign stall     = req_s & ~done_r;
    assign done      = done_r;
    assign err       = err_r;
    assign load_data = load_data_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles spent in REQ+RESP before abort (legal 2..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 load_en  in  1  load request from ctrl, held high until done.
REQ-005 store_en  in  1  store request from ctrl, held high until done.
REQ-006 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  byte address (rs1+imm from ex).
REQ-008 store_data  in  32  rs2 data, low bits significant.
REQ-009 stall  out  1  core holds PC/register file while high.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle error pulse, coincident with done.
REQ-012 load_data  out  32  extended load result, valid while done=1.
REQ-013 mem_req, mem_we  out  1 each  bus request / write.
REQ-014 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 mem_be, mem_wdata  out  4 / 32  byte enables / lane-shifted write data.
REQ-016 mem_gnt, mem_rvalid, mem_err  in  1 each  grant / response valid / response error.
REQ-017 mem_rdata  in  32  read word, valid with mem_rvalid.

Function
REQ-018 FSM states IDLE, REQ, RESP, DONE; registered state.
REQ-019 IDLE: load_en|store_en captures addr, funct3, store_data, we (store wins if both) -> REQ.
REQ-020 REQ: mem_req=1, outputs stable; mem_gnt=1 -> RESP; mem_rvalid here ignored.
REQ-021 RESP: mem_req=0; mem_rvalid=1 -> DONE, capturing extended rdata and mem_err.
REQ-022 DONE: done=1 one cycle, err=mem_err, -> IDLE; enables seen in DONE not captured.
REQ-023 stall = (load_en|store_en) & ~done, combinational.
REQ-024 Minimum latency: enable cycle N, mem_req N+1, done N+3 (gnt at N+1, rvalid at N+2).
REQ-025 Byte lanes: B be=1<<addr[1:0]; H be=3<<{addr[1],0}; W be=4'hF; wdata replicates low byte/half across lanes.
REQ-026 Loads select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend; stores give load_data=0.
REQ-027 Illegal funct3 (011,110,111): no bus request, IDLE -> DONE, err=1, load_data=0.
REQ-028 Timeout counter, 8-bit, cleared on IDLE exit, increments in REQ/RESP; reaching TIMEOUT -> DONE, err=1, load_data=0, mem_req dropped.
REQ-029 Counter saturates, never wraps.

Reset
REQ-030 rst_n low: state IDLE, counter 0, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-transaction drops mem_req asynchronously; outstanding response after reset ignored.

Configuration
REQ-032 MEM_ACCESS_MISALIGN_CHK_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no bus request, IDLE -> DONE, err=1, load_data=0.
REQ-033 Undefined: misaligned offset bits ignored (H uses addr[1] only, W ignores addr[1:0]), access proceeds normally.

Structure
REQ-034 Package mem_access_pkg: state enum, funct3 size constants, TIMEOUT default, byte-enable masks.
REQ-035 Sub-module mem_lane_align: combinational be/wdata generation and load extract/extend.

Verification
REQ-036 LW addr 0x100, gnt immediate, rvalid next cycle rdata 0xDEADBEEF -> done at N+3, load_data 0xDEADBEEF, err=0.
REQ-037 LB addr 0x103, rdata 0x80xxxxxx -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, store_data 0x1234ABCD -> mem_be 4'b1100, mem_wdata 0xABCDABCD, mem_addr 0x200.
REQ-039 gnt withheld, TIMEOUT=8 -> done and err pulse 8 cycles after REQ entry, mem_req low after.
REQ-040 LW addr 0x101 -> with macro: done+err at N+1, no mem_req; without: mem_addr 0x100, normal completion.
REQ-041 rst_n low while in RESP -> mem_req 0, state IDLE; late rvalid produces no done.
